// File: rtl/alu_pkg.sv
// Shared types and default widths for the alu_seq slice.
package alu_pkg;

  localparam int unsigned ALU_W_DEF     = 6;
  localparam int unsigned ALU_CNT_W_DEF = 16;

  // Encodings 5-7 are illegal and produce result 0 with ovf set.
  typedef enum logic [2:0] {
    OP_SHADD = 3'd0,
    OP_ADD3  = 3'd1,
    OP_NEG   = 3'd2,
    OP_ABSD  = 3'd3,
    OP_MUL   = 3'd4
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Operation/result handshake bundle for alu_seq; master drives operations.
interface alu_seq_if
  import alu_pkg::*;
#(
  parameter int unsigned W     = ALU_W_DEF,
  parameter int unsigned CNT_W = ALU_CNT_W_DEF
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic signed [W-1:0]  a;
  logic signed [W-1:0]  b;
  logic [2:0]           opr;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [W-1:0]  result;
  logic                 ovf;
  logic [CNT_W-1:0]     count;

  modport master (
    output in_valid, a, b, opr, out_ready,
    input  in_ready, out_valid, result, ovf, count
  );

  modport slave (
    input  in_valid, a, b, opr, out_ready,
    output in_ready, out_valid, result, ovf, count
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Iterative signed shift-add multiplier: W iterations after start, done on the last.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int unsigned W = ALU_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic signed [W-1:0]   a_i,
  input  logic signed [W-1:0]   b_i,
  output logic                  done_o,
  output logic signed [2*W-1:0] product_o
);

  localparam int unsigned IW = $clog2(W);

  logic                  busy_q;
  logic [IW-1:0]         iter_q;
  logic signed [2*W-1:0] mcand_q;
  logic [W-1:0]          mplier_q;
  logic signed [2*W-1:0] acc_q;
  logic signed [2*W-1:0] term;
  logic signed [2*W-1:0] sum;
  logic                  last;

  // The multiplier MSB carries weight -2^(W-1), so the final partial product is subtracted.
  always_comb begin
    last = (iter_q == IW'(W - 1));
    term = mplier_q[0] ? mcand_q : '0;
    sum  = last ? (acc_q - term) : (acc_q + term);
  end

  assign done_o    = busy_q && last;
  assign product_o = sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      iter_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      iter_q   <= '0;
      mcand_q  <= {{W{a_i[W-1]}}, a_i};
      mplier_q <= b_i;
      acc_q    <= '0;
    end else if (busy_q) begin
      acc_q    <= sum;
      mcand_q  <= mcand_q <<< 1;
      mplier_q <= mplier_q >> 1;
      iter_q   <= iter_q + IW'(1);
      if (last) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential signed ALU with valid/ready handshake and completed-result counter.
// Define ALU_SEQ_SAT_EN to saturate overflowing results instead of wrapping.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned W     = ALU_W_DEF,
  parameter int unsigned CNT_W = ALU_CNT_W_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);

  localparam int unsigned EW = W + 3;
  localparam int unsigned FW = 2 * W;

  state_e state_q, state_d;

  logic                 out_valid_q, out_valid_d;
  logic signed [W-1:0]  result_q, result_d;
  logic                 ovf_q, ovf_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic                 accept;
  logic                 mul_start;
  logic                 mul_done;
  logic signed [FW-1:0] mul_prod;
  logic                 load;
  logic                 illegal;
  logic signed [EW-1:0] a_x, b_x, diff, alu_val;
  logic signed [FW-1:0] full;
  logic [FW-W:0]        hi;
  logic                 res_ovf;
  logic signed [W-1:0]  res_val;

  assign bus.in_ready  = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.ovf       = ovf_q;
  assign bus.count     = count_q;

  assign accept    = bus.in_valid && bus.in_ready;
  assign mul_start = accept && (bus.opr == OP_MUL);
  assign load      = mul_done || (accept && (bus.opr != OP_MUL));

  alu_mul_seq #(.W(W)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (mul_start),
    .a_i       (bus.a),
    .b_i       (bus.b),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_MUL;
      ST_MUL:  if (mul_done)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    illegal = 1'b0;
    alu_val = '0;
    a_x     = {{3{bus.a[W-1]}}, bus.a};
    b_x     = {{3{bus.b[W-1]}}, bus.b};
    diff    = (a_x <<< 1) - b_x;
    case (bus.opr)
      OP_SHADD: alu_val = (a_x <<< 2) + (b_x >>> 1);
      OP_ADD3:  alu_val = a_x + b_x + (b_x <<< 1);
      OP_NEG:   alu_val = -b_x;
      OP_ABSD:  alu_val = diff[EW-1] ? -diff : diff;
      OP_MUL:   alu_val = '0;
      default:  illegal = 1'b1;
    endcase

    // A finishing multiply never coincides with an acceptance, so it takes the shared path.
    full    = mul_done ? mul_prod : {{(FW-EW){alu_val[EW-1]}}, alu_val};
    hi      = full[FW-1:W-1];
    res_ovf = !((&hi) || !(|hi));
`ifdef ALU_SEQ_SAT_EN
    if (res_ovf) begin
      res_val = full[FW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      res_val = full[W-1:0];
    end
`else
    res_val = full[W-1:0];
`endif
    if (illegal && !mul_done) begin
      res_val = '0;
      res_ovf = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    count_d     = count_q;
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
      count_d     = count_q + CNT_W'(1);
    end
    if (load) begin
      out_valid_d = 1'b1;
      result_d    = res_val;
      ovf_d       = res_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed vector bench for alu_seq at W=6; honours ALU_SEQ_SAT_EN for expected results.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int unsigned W     = 6;
  localparam int unsigned CNT_W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  alu_seq_if #(.W(W), .CNT_W(CNT_W)) bus ();

  alu_seq #(.W(W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int op;
    int res;
    int ovf;
    int lat;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_cnt = 0;

  function automatic int sw(input int wrap_v, input int sat_v);
`ifdef ALU_SEQ_SAT_EN
    return sat_v;
`else
    return wrap_v;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int a, input int b, input int op);
    bus.a        = a[W-1:0];
    bus.b        = b[W-1:0];
    bus.opr      = op[2:0];
    bus.in_valid = 1'b1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: in_ready got 0 after %0d cycles, expected 1", name, n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time got exhausted, expected finish");
    $fatal(1);
  end

  initial begin
    int  lat;
    int  base;
    int  seen;
    int  bb_a[4];
    int  bb_b[4];
    int  bb_r[4];
    vec_t v;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.opr       = '0;
    bus.out_ready = 1'b1;

    vecs.push_back('{a:  3, b:   5, op: 0, res: 14,          ovf: 0, lat: 1});
    vecs.push_back('{a: 10, b:  10, op: 1, res: sw(-24, 31), ovf: 1, lat: 1});
    vecs.push_back('{a:  0, b: -32, op: 2, res: sw(-32, 31), ovf: 1, lat: 1});
    vecs.push_back('{a:  2, b:   9, op: 3, res: 5,           ovf: 0, lat: 1});
    vecs.push_back('{a: -3, b:   7, op: 4, res: -21,         ovf: 0, lat: 7});
    vecs.push_back('{a:  1, b:   1, op: 5, res: 0,           ovf: 1, lat: 1});
    vecs.push_back('{a: 31, b: -32, op: 7, res: 0,           ovf: 1, lat: 1});
    vecs.push_back('{a: -8, b:  -1, op: 0, res: sw(31, -32), ovf: 1, lat: 1});
    vecs.push_back('{a: -8, b:   0, op: 0, res: -32,         ovf: 0, lat: 1});
    vecs.push_back('{a:-32, b: -32, op: 4, res: sw(0, 31),   ovf: 1, lat: 7});
    vecs.push_back('{a:  5, b:  -6, op: 4, res: -30,         ovf: 0, lat: 7});
    vecs.push_back('{a:-32, b:  31, op: 3, res: 31,          ovf: 1, lat: 1});
    vecs.push_back('{a: -2, b: -10, op: 1, res: -32,         ovf: 0, lat: 1});
    vecs.push_back('{a:  0, b:  31, op: 2, res: -31,         ovf: 0, lat: 1});
    vecs.push_back('{a:  7, b:   4, op: 4, res: 28,          ovf: 0, lat: 7});
    vecs.push_back('{a:  7, b:   3, op: 0, res: 29,          ovf: 0, lat: 1});
    vecs.push_back('{a:  1, b:  11, op: 1, res: sw(-30, 31), ovf: 1, lat: 1});
    vecs.push_back('{a: -1, b:  -1, op: 4, res: 1,           ovf: 0, lat: 7});

    // Reset state
    tick();
    tick();
    chk("rst out_valid", int'(bus.out_valid), 0);
    chk("rst result",    int'(bus.result),    0);
    chk("rst ovf",       int'(bus.ovf),       0);
    chk("rst count",     int'(bus.count),     0);
    chk("rst in_ready",  int'(bus.in_ready),  1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Table-driven single operations, consumer always ready
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      wait_ready($sformatf("v%0d", i));
      drive(v.a, v.b, v.op);
      tick();
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 30) begin
        tick();
        lat++;
      end
      chk($sformatf("v%0d latency", i), lat, v.lat);
      chk($sformatf("v%0d result", i), int'(bus.result), v.res);
      chk($sformatf("v%0d ovf", i), int'(bus.ovf), v.ovf);
      tick();
      exp_cnt++;
      chk($sformatf("v%0d count", i), int'(bus.count), exp_cnt);
      chk($sformatf("v%0d out_valid clear", i), int'(bus.out_valid), 0);
    end

    // Multiply with consumer stalled for 3 cycles
    bus.out_ready = 1'b0;
    wait_ready("stall mul");
    drive(-3, 7, 4);
    tick();
    bus.in_valid = 1'b0;
    for (int k = 1; k <= int'(W); k++) begin
      chk($sformatf("stall in_ready c%0d", k), int'(bus.in_ready), 0);
      chk($sformatf("stall out_valid c%0d", k), int'(bus.out_valid), 0);
      tick();
    end
    chk("stall out_valid c7", int'(bus.out_valid), 1);
    chk("stall result c7", int'(bus.result), -21);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall hold valid %0d", k), int'(bus.out_valid), 1);
      chk($sformatf("stall hold result %0d", k), int'(bus.result), -21);
      chk($sformatf("stall hold ovf %0d", k), int'(bus.ovf), 0);
      chk($sformatf("stall hold count %0d", k), int'(bus.count), exp_cnt);
      chk($sformatf("stall hold in_ready %0d", k), int'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("stall drain in_ready", int'(bus.in_ready), 1);
    tick();
    exp_cnt++;
    chk("stall count after drain", int'(bus.count), exp_cnt);
    chk("stall out_valid after drain", int'(bus.out_valid), 0);
    tick();
    chk("stall count once", int'(bus.count), exp_cnt);

    // Back-to-back shift-add operations
    bb_a = '{1, 2, -1, 0};
    bb_b = '{0, 2, -2, 7};
    bb_r = '{4, 9, -5, 3};
    base = exp_cnt;
    drive(bb_a[0], bb_b[0], 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("b2b result %0d", k), int'(bus.result), bb_r[k]);
      chk($sformatf("b2b out_valid %0d", k), int'(bus.out_valid), 1);
      chk($sformatf("b2b in_ready %0d", k), int'(bus.in_ready), 1);
      chk($sformatf("b2b count %0d", k), int'(bus.count), base + k);
      if (k < 3) drive(bb_a[k+1], bb_b[k+1], 0);
      else bus.in_valid = 1'b0;
    end
    tick();
    chk("b2b final count", int'(bus.count), base + 4);
    chk("b2b final out_valid", int'(bus.out_valid), 0);

    // Reset in the third cycle of a multiply
    wait_ready("abort mul");
    drive(5, 5, 4);
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", int'(bus.out_valid), 0);
    chk("abort count", int'(bus.count), 0);
    chk("abort in_ready in reset", int'(bus.in_ready), 1);
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    chk("abort in_ready after release", int'(bus.in_ready), 1);
    seen = 0;
    for (int k = 0; k < int'(W) + 2; k++) begin
      if (bus.out_valid) seen++;
      tick();
    end
    chk("abort no result", seen, 0);
    chk("abort count held", int'(bus.count), 0);

    // Recovery after abort
    drive(3, 5, 0);
    tick();
    bus.in_valid = 1'b0;
    chk("recover result", int'(bus.result), 14);
    chk("recover out_valid", int'(bus.out_valid), 1);
    tick();
    chk("recover count", int'(bus.count), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter W, default 6: signed operand and result width, W >= 4.
REQ-002 Parameter CNT_W, default 16: width of the completed-operation counter.
REQ-003 clk  input  1  rising-edge clock; the block has a single clock domain.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand and opcode present.
REQ-006 in_ready  output  1  block accepts an operation this cycle.
REQ-007 a, b  input  W each  signed operands.
REQ-008 opr  input  3  opcode.
REQ-009 out_valid  output  1  result held valid.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 result  output  W  signed result.
REQ-012 ovf  output  1  true result does not fit in signed W.
REQ-013 count  output  CNT_W  completed output handshakes.

Function
REQ-014 Acceptance SHALL occur on in_valid && in_ready; in_ready = (state==IDLE) && (!out_valid || out_ready), combinational.
REQ-015 Ops SHALL be computed at W+3 internal signed precision (2W for multiply): 0: (a<<<2)+(b>>>1); 1: a+3b; 2: -b; 3: |2a-b|; 4: a*b.
REQ-016 Opcodes 5-7 are illegal: result = 0 and ovf = 1, with single-cycle latency.
REQ-017 Ops 0-3 and illegal ops SHALL load the output register at the acceptance edge, so out_valid rises 1 cycle after acceptance.
REQ-018 Op 4 SHALL run as an iterative signed shift-add over exactly W cycles, with out_valid rising W+1 cycles after acceptance.
REQ-019 FSM states: IDLE and MUL.
- IDLE -> MUL on an accepted op 4.
- MUL -> IDLE on the final iteration, which writes the output register.
- No other transitions.
REQ-020 in_ready SHALL be 0 throughout MUL. The output register is guaranteed free when MUL completes, because acceptance required it free or draining.
REQ-021 While out_valid && !out_ready, result and ovf SHALL hold stable.
REQ-022 out_valid SHALL clear on a handshake unless a new result loads on the same edge.
REQ-023 ovf SHALL be 1 when the full-precision value lies outside [-2^(W-1), 2^(W-1)-1]; result handling on overflow is set by REQ-027.
REQ-024 count SHALL increment by 1 per out_valid && out_ready and wrap modulo 2^CNT_W.

Reset
REQ-025 While rst_n=0, the block SHALL hold:
- state = IDLE
- out_valid = 0, result = 0, ovf = 0, count = 0
- multiplier iteration counter and accumulator = 0
REQ-026 Reset asserted during MUL SHALL abort the multiply with no output produced. in_ready SHALL be 1 in the first cycle after rst_n rises.

Configuration
REQ-027 Macro ALU_SEQ_SAT_EN selects overflow handling; ovf behaves identically in both builds.
- Defined: an overflowing result saturates to 2^(W-1)-1 or -2^(W-1) by the sign of the true value.
- Undefined: result is the low W bits of the true value (two's-complement wrap).

Structure
REQ-028 Shared package alu_pkg SHALL hold:
- the opcode enum (OP_SHADD, OP_ADD3, OP_NEG, OP_ABSD, OP_MUL)
- the FSM state enum
- default-width constants
REQ-029 The iterative multiplier SHALL be a sub-module alu_mul_seq with start/done, operands and a 2W-bit product. All other ops stay inline in alu_seq.

Verification (W=6)
REQ-030 a=3, b=5, opr=0 -> result=14, ovf=0; out_valid 1 cycle after acceptance.
REQ-031 a=10, b=10, opr=1 -> ovf=1; result=-24 without the macro, 31 with ALU_SEQ_SAT_EN.
REQ-032 a=0, b=-32, opr=2 -> ovf=1; result=-32 wrapped, 31 saturated. Then a=2, b=9, opr=3 -> result=5, ovf=0.
REQ-033 a=-3, b=7, opr=4 with out_ready low for 3 cycles ->
- in_ready=0 for 6 cycles
- out_valid rises at cycle 7 with result=-21, held stable until out_ready
- count increments exactly once
REQ-034 Back-to-back opr=0 with out_ready=1 -> one result per cycle, in_ready stays 1, count advances by 1 each cycle.
REQ-035 rst_n pulsed low in cycle 3 of MUL -> out_valid=0, count=0, state=IDLE; in_ready=1 in the first cycle after release; no result is emitted.
